// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between operand fetch, the execute stage and writeback.
// master = upstream/downstream environment, slave = the execute unit.
interface alu_exec_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered execute stage: single-cycle logic/add/sub/pass plus an iterative
// shift-add multiplier, with Z/N/C flags held until writeback consumes them.
module alu_exec_unit #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_next;
    logic               r_flag_z;
    logic               r_flag_n;
    logic               r_flag_c;
    logic               w_flag_c_next;
    logic               w_load;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] w_mcand_next;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_acc_sum;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   w_mplier_next;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_next;
    logic               w_accept;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);

    // Single-cycle datapath; the extra top bit of w_sub is the unsigned borrow.
    always_comb begin
        w_add     = {1'b0, bus.a} + {1'b0, bus.b};
        w_sub     = {1'b0, bus.a} - {1'b0, bus.b};
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (bus.op)
            OP_AND: w_alu_res = bus.a & bus.b;
            OP_OR:  w_alu_res = bus.a | bus.b;
            OP_XOR: w_alu_res = bus.a ^ bus.b;
            OP_NOT: w_alu_res = ~bus.a;
            OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
            end
            OP_SUB: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = w_sub[WIDTH];
            end
            OP_MUL: w_alu_res = '0;
            default: w_alu_res = bus.a;
        endcase
    end

    assign w_acc_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        w_flag_c_next = r_flag_c;
        w_load        = 1'b0;
        w_mcand_next  = r_mcand;
        w_mplier_next = r_mplier;
        w_acc_next    = r_acc;
        w_cnt_next    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.op == OP_MUL) begin
                        w_mcand_next  = {{WIDTH{1'b0}}, bus.a};
                        w_mplier_next = bus.b;
                        w_acc_next    = '0;
                        w_cnt_next    = CNT_INIT;
                        w_state_next  = ST_MUL;
                    end else begin
                        w_result_next = w_alu_res;
                        w_flag_c_next = w_alu_c;
                        w_load        = 1'b1;
                        w_state_next  = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                w_acc_next    = w_acc_sum;
                w_mcand_next  = {r_mcand[2*WIDTH-2:0], 1'b0};
                w_mplier_next = {1'b0, r_mplier[WIDTH-1:1]};
                w_cnt_next    = r_cnt - CNT_ONE;
                // Last partial product is folded in on the same edge that publishes the result.
                if (r_cnt == CNT_ONE) begin
                    w_result_next = w_acc_sum[WIDTH-1:0];
                    w_flag_c_next = |w_acc_sum[2*WIDTH-1:WIDTH];
                    w_load        = 1'b1;
                    w_state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mcand  <= w_mcand_next;
            r_mplier <= w_mplier_next;
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            if (w_load) begin
                r_result <= w_result_next;
                r_flag_z <= (w_result_next == '0);
                r_flag_n <= w_result_next[WIDTH-1];
                r_flag_c <= w_flag_c_next;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state == ST_MUL);
    assign bus.result    = r_result;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_n    = r_flag_n;
    assign bus.flag_c    = r_flag_c;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int W = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    typedef struct {
        int unsigned res;
        bit          c;
        bit [2:0]    op;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vectors;
    int   n_miscompares;

    alu_exec_unit_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, then truncate to W bits.
    function automatic exp_t ref_model(input bit [2:0] op, input int unsigned a, input int unsigned b);
        exp_t        e;
        int unsigned full;
        e.op = op;
        e.c  = 1'b0;
        case (op)
            3'd0: full = a & b;
            3'd1: full = a | b;
            3'd2: full = a ^ b;
            3'd3: full = ~a;
            3'd4: begin full = a + b; e.c = (full > MASK); end
            3'd5: begin full = a - b; e.c = (a < b); end
            3'd6: begin full = a * b; e.c = ((full >> W) != 0); end
            default: full = a;
        endcase
        e.res = full & MASK;
        return e;
    endfunction

    task automatic run_op(input bit [2:0] op, input int unsigned a, input int unsigned b, input int hold);
        exp_t e;
        int   lat;
        e = ref_model(op, a & MASK, b & MASK);
        @(negedge clk);
        check("in_ready_before", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = W'(a);
        bus.b         = W'(b);
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        lat = 1;
        if (op == 3'd6) check("busy_mul", bus.busy, 1);
        while (!bus.out_valid && lat <= W + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, (op == 3'd6) ? W + 1 : 1);
        check("result", bus.result, e.res);
        check("flag_z", bus.flag_z, (e.res == 0) ? 1 : 0);
        check("flag_n", bus.flag_n, (e.res >> (W - 1)) & 1);
        check("flag_c", bus.flag_c, e.c);
        check("in_ready_done", bus.in_ready, 0);
        check("busy_done", bus.busy, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op       = op ^ 3'b001;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.result, e.res);
            check("hold_flag_n", bus.flag_n, (e.res >> (W - 1)) & 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", bus.in_ready, 1);
        check("release_out_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_flags"}, {bus.flag_z, bus.flag_n, bus.flag_c}, 0);
    endtask

    initial begin
        exp_t        sb[$];
        bit [2:0]    q_op[$];
        int unsigned q_a[$];
        int unsigned q_b[$];
        exp_t        e;
        int          cyc;
        int          last_acc;
        int          exp_gap;
        int          guard;
        int          idx;
        bit          acc;

        n_vectors     = 0;
        n_miscompares = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the test plan.
        run_op(3'd0, 32'hF0, 32'h3C, 0);
        run_op(3'd4, 32'hFF, 32'h01, 1);
        run_op(3'd5, 32'h05, 32'h07, 0);
        run_op(3'd6, 32'h0D, 32'h0B, 0);
        run_op(3'd6, 32'h10, 32'h10, 2);
        run_op(3'd3, 32'h55, 32'h00, 5);

        // Asynchronous reset in the 4th multiply cycle.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 3'd6;
        bus.a        = 8'h0D;
        bus.b        = 8'h0B;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("busy_before_abort", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", bus.out_valid, 0);
        end
        run_op(3'd7, 32'h80, 32'h00, 0);

        // Randomized single ops with random backpressure.
        for (int i = 0; i < 40; i++) begin
            int unsigned ra;
            int unsigned rb;
            ra = $urandom_range(0, MASK);
            rb = $urandom_range(0, MASK);
            if ($urandom_range(0, 5) == 0) ra = MASK;
            if ($urandom_range(0, 5) == 0) rb = 0;
            run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3));
        end

        // Back-to-back stream: in_valid and out_ready held high.
        for (int i = 0; i < 16; i++) begin
            q_op.push_back(3'($urandom_range(0, 7)));
            q_a.push_back($urandom_range(0, MASK));
            q_b.push_back($urandom_range(0, MASK));
        end
        idx           = 0;
        cyc           = 0;
        last_acc      = -1;
        exp_gap       = 0;
        guard         = 0;
        bus.out_ready = 1'b1;
        while ((idx < 16 || sb.size() > 0) && guard < 1000) begin
            guard++;
            @(negedge clk);
            if (idx < 16) begin
                bus.in_valid = 1'b1;
                bus.op       = q_op[idx];
                bus.a        = W'(q_a[idx]);
                bus.b        = W'(q_b[idx]);
            end else begin
                bus.in_valid = 1'b0;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (last_acc >= 0) check("b2b_gap", cyc - last_acc, exp_gap);
                last_acc = cyc;
                exp_gap  = (q_op[idx] == 3'd6) ? W + 2 : 2;
                sb.push_back(ref_model(q_op[idx], q_a[idx], q_b[idx]));
                idx++;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("b2b_unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("b2b_result", bus.result, e.res);
                    check("b2b_flag_c", bus.flag_c, e.c);
                    check("b2b_flag_z", bus.flag_z, (e.res == 0) ? 1 : 0);
                end
            end
        end
        check("b2b_issued", idx, 16);
        check("b2b_drained", sb.size(), 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
